// File: rtl/load_store_controller_if.sv
// Request/acknowledge data-memory port between the load/store controller (master)
// and the data memory (slave).
interface load_store_controller_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_controller.sv
// MEM-stage load/store sequencer for the RV32I pipeline: latches one access, runs the
// req/ack memory handshake, stalls the pipeline and returns the extended load result.
module load_store_controller #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           memRead,
  input  logic                           memWrite,
  input  logic [5:0]                     aluSelect,
  input  logic [ADDR_W-1:0]              address,
  input  logic [31:0]                    storeData,
  load_store_controller_if.master        memBus,
  output logic                           stall,
  output logic [31:0]                    loadData,
  output logic                           done,
  output logic                           misaligned,
  output logic                           bus_error
);

  localparam logic [5:0] SEL_LB  = 6'b001011;
  localparam logic [5:0] SEL_LH  = 6'b001100;
  localparam logic [5:0] SEL_LW  = 6'b001101;
  localparam logic [5:0] SEL_LBU = 6'b001110;
  localparam logic [5:0] SEL_LHU = 6'b001111;
  localparam logic [5:0] SEL_SB  = 6'b010000;
  localparam logic [5:0] SEL_SH  = 6'b010001;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       selReg;
  logic [1:0]       offReg;

  logic       isByte;
  logic       isHalf;
  logic       isWrite;
  logic       addrMisaligned;
  logic       accept;
  logic [1:0] off;
  logic [3:0] wstrbNext;
  logic [31:0] wdataNext;

  function automatic logic [31:0] extractLoad(input logic [5:0]  sel,
                                              input logic [1:0]  byteOff,
                                              input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = rdata >> {byteOff, 3'b000};
    case (sel)
      SEL_LB:  res = {{24{shifted[7]}}, shifted[7:0]};
      SEL_LBU: res = {24'd0, shifted[7:0]};
      SEL_LH:  res = {{16{shifted[15]}}, shifted[15:0]};
      SEL_LHU: res = {16'd0, shifted[15:0]};
      SEL_LW:  res = rdata;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  always_comb begin
    off            = address[1:0];
    isByte         = (aluSelect == SEL_LB) || (aluSelect == SEL_LBU) || (aluSelect == SEL_SB);
    isHalf         = (aluSelect == SEL_LH) || (aluSelect == SEL_LHU) || (aluSelect == SEL_SH);
    isWrite        = memWrite & ~memRead;
    addrMisaligned = isHalf ? address[0] : (!isByte && (off != 2'b00));
    accept         = (state == IDLE) && (memRead || memWrite) && !addrMisaligned;

    wstrbNext = 4'b0000;
    wdataNext = 32'd0;
    if (isWrite) begin
      if (isByte) begin
        wstrbNext = 4'b0001 << off;
        wdataNext = {4{storeData[7:0]}};
      end else if (isHalf) begin
        wstrbNext = 4'b0011 << off;
        wdataNext = {2{storeData[15:0]}};
      end else begin
        wstrbNext = 4'b1111;
        wdataNext = storeData;
      end
    end
  end

  // Handshake outputs decode straight from the state; stall covers the accept cycle too.
  assign misaligned     = (state == IDLE) && (memRead || memWrite) && addrMisaligned;
  assign stall          = accept || (state == REQ);
  assign memBus.mem_req = (state == REQ);
  assign done           = (state == DONE);
  assign bus_error      = (state == ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      selReg           <= '0;
      offReg           <= '0;
      loadData         <= '0;
      memBus.mem_we    <= 1'b0;
      memBus.mem_addr  <= '0;
      memBus.mem_wdata <= '0;
      memBus.mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            selReg           <= aluSelect;
            offReg           <= off;
            cnt              <= '0;
            memBus.mem_we    <= isWrite;
            memBus.mem_addr  <= {address[ADDR_W-1:2], 2'b00};
            memBus.mem_wdata <= wdataNext;
            memBus.mem_wstrb <= wstrbNext;
            state            <= REQ;
          end
        end
        REQ: begin
          // An ack arriving on the final timeout cycle still completes the access.
          if (memBus.mem_ack) begin
            loadData <= memBus.mem_we ? 32'd0 : extractLoad(selReg, offReg, memBus.mem_rdata);
            state    <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            loadData <= 32'd0;
            state    <= ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_controller.sv
// Directed and randomized bench for load_store_controller with an arithmetic reference
// model of lane selection, extension, strobes and handshake timing.
module tb_load_store_controller;

  localparam int TIMEOUT = 4;
  localparam int ADDR_W  = 32;
  localparam int NEVER   = 1000;

  localparam logic [5:0] LB  = 6'b001011;
  localparam logic [5:0] LH  = 6'b001100;
  localparam logic [5:0] LW  = 6'b001101;
  localparam logic [5:0] LBU = 6'b001110;
  localparam logic [5:0] LHU = 6'b001111;
  localparam logic [5:0] SB  = 6'b010000;
  localparam logic [5:0] SH  = 6'b010001;
  localparam logic [5:0] SW  = 6'b010010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [5:0]  aluSelect = 6'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] storeData = 32'd0;
  logic        stall;
  logic [31:0] loadData;
  logic        done;
  logic        misaligned;
  logic        bus_error;

  int checks = 0;
  int failures = 0;

  load_store_controller_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_controller #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .aluSelect  (aluSelect),
    .address    (address),
    .storeData  (storeData),
    .memBus     (bus),
    .stall      (stall),
    .loadData   (loadData),
    .done       (done),
    .misaligned (misaligned),
    .bus_error  (bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int accSize(input logic [5:0] sel);
    if (sel == LB || sel == LBU || sel == SB) return 1;
    if (sel == LH || sel == LHU || sel == SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [5:0] sel, input int off,
                                            input logic [31:0] rdata);
    int unsigned v;
    v = rdata >> (8 * off);
    case (sel)
      LB:  begin v = v % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      LBU: v = v % 256;
      LH:  begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      LHU: v = v % 65536;
      LW:  v = rdata;
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] modelWstrb(input logic [5:0] sel, input int off);
    int unsigned m;
    m = ((1 << accSize(sel)) - 1) << off;
    return m % 16;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [5:0] sel, input logic [31:0] sd);
    case (accSize(sel))
      1:       return (sd % 256) * 32'h0101_0101;
      2:       return (sd % 65536) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  // Entered and left one time unit after a rising edge with the DUT idle.
  task automatic runAccess(input logic rd, input logic wr, input logic [5:0] sel,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] rdata, input int waitCyc,
                           input int resetAt, input bit lateAck, output int stallCnt);
    logic isWr;
    logic mis;
    int   off;
    int   k;
    bit   finished;
    off      = addr % 4;
    isWr     = wr & ~rd;
    mis      = (addr % accSize(sel)) != 0;
    stallCnt = 0;
    memRead = rd; memWrite = wr; aluSelect = sel; address = addr; storeData = sd;
    @(negedge clk);
    if (stall) stallCnt++;
    check("misaligned", misaligned, mis);
    check("stall_accept", stall, !mis);
    check("req_idle", bus.mem_req, 1'b0);
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0;
    address = $urandom; storeData = $urandom; aluSelect = 6'($urandom);
    if (mis) begin
      @(negedge clk);
      check("req_after_mis", bus.mem_req, 1'b0);
      check("stall_after_mis", stall, 1'b0);
      @(posedge clk); #1;
      return;
    end
    k = 0;
    finished = 0;
    while (!finished) begin
      bus.mem_ack   = (k == waitCyc);
      bus.mem_rdata = (k == waitCyc) ? rdata : $urandom;
      if (k == resetAt) reset = 1'b1;
      @(negedge clk);
      if (stall) stallCnt++;
      check("req_high", bus.mem_req, 1'b1);
      check("stall_req", stall, 1'b1);
      check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
      check("mem_we", bus.mem_we, isWr);
      check("mem_wstrb", bus.mem_wstrb, isWr ? modelWstrb(sel, off) : 32'd0);
      if (isWr) check("mem_wdata", bus.mem_wdata, modelWdata(sel, sd));
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      if (k == resetAt) begin
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        check("req_after_reset", bus.mem_req, 1'b0);
        check("stall_after_reset", stall, 1'b0);
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("done_after_reset", done, 1'b0);
        check("req_late_ack", bus.mem_req, 1'b0);
        @(posedge clk); #1;
        finished = 1;
      end else if (k == waitCyc) begin
        @(negedge clk);
        if (stall) stallCnt++;
        check("done", done, 1'b1);
        check("stall_done", stall, 1'b0);
        check("req_done", bus.mem_req, 1'b0);
        check("bus_error_done", bus_error, 1'b0);
        check("loadData", loadData, isWr ? 32'd0 : modelLoad(sel, off, rdata));
        @(posedge clk); #1;
        finished = 1;
      end else if (k == TIMEOUT - 1) begin
        @(negedge clk);
        check("bus_error", bus_error, 1'b1);
        check("done_err", done, 1'b0);
        check("stall_err", stall, 1'b0);
        check("loadData_err", loadData, 32'd0);
        @(posedge clk); #1;
        if (lateAck) begin
          bus.mem_ack = 1'b1;
          @(negedge clk);
          check("req_late_ack", bus.mem_req, 1'b0);
          @(posedge clk); #1;
          bus.mem_ack = 1'b0;
          @(negedge clk);
          check("done_late_ack", done, 1'b0);
          check("bus_error_late_ack", bus_error, 1'b0);
          @(posedge clk); #1;
        end
        finished = 1;
      end else begin
        k++;
      end
    end
  endtask

  initial begin
    logic [5:0] sels [8];
    logic [5:0] sel;
    logic       rd;
    logic       wr;
    int         sc;
    sels = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bus_error", bus_error, 1'b0);
    check("rst_misaligned", misaligned, 1'b0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_wstrb", bus.mem_wstrb, 32'd0);
    check("rst_we", bus.mem_we, 1'b0);
    check("rst_loadData", loadData, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    runAccess(1, 0, LB, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, -1, 0, sc);
    check("lb_stall_cycles", sc, 2);
    runAccess(1, 0, LHU, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 3, -1, 0, sc);
    check("lhu_stall_cycles", sc, 5);
    runAccess(0, 1, SH, 32'h0000_3002, 32'h0000_A5A5, 32'hDEAD_BEEF, 1, -1, 0, sc);
    runAccess(1, 0, LW, 32'h0000_4001, 32'd0, 32'd0, 0, -1, 0, sc);
    runAccess(1, 0, LW, 32'h0000_4000, 32'd0, 32'h1234_5678, NEVER, -1, 1, sc);
    check("timeout_stall_cycles", sc, TIMEOUT + 1);
    runAccess(1, 0, LW, 32'h0000_4004, 32'd0, 32'hCAFE_F00D, TIMEOUT - 1, -1, 0, sc);
    runAccess(1, 0, LW, 32'h0000_4008, 32'd0, 32'h1111_2222, NEVER, 1, 0, sc);
    runAccess(1, 0, LBU, 32'h0000_5000, 32'd0, 32'h0000_0081, 0, -1, 0, sc);
    runAccess(1, 0, LH, 32'h0000_6002, 32'd0, 32'h8001_7FFF, 2, -1, 0, sc);
    runAccess(0, 1, SB, 32'h0000_7001, 32'h1234_56C3, 32'd0, 0, -1, 0, sc);
    runAccess(1, 1, LW, 32'h0000_8000, 32'hFFFF_FFFF, 32'h0BAD_F00D, 0, -1, 0, sc);

    for (int i = 0; i < 80; i++) begin
      sel = sels[$urandom_range(0, 7)];
      rd  = (sel != SB) && (sel != SH) && (sel != SW);
      wr  = !rd || ($urandom_range(0, 4) == 0);
      runAccess(rd, wr, sel, $urandom & 32'h0000_FFFF, $urandom, $urandom,
                $urandom_range(0, TIMEOUT), -1, $urandom_range(0, 1) == 1, sc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
